// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory subsystem.
//   DMEM_ADDR_W / DMEM_DATA_W : geometry of the single-port data memory
//   dmem_port_e               : requester identity, used to route read data back
package mips_mem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    PORT_PIPE = 1'b0,  // pipeline memory stage
    PORT_LOAD = 1'b1   // loader / DMA
  } dmem_port_e;

endpackage : mips_mem_pkg

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory (1-cycle registered read) between the
//   pipeline memory stage (port 0, fixed priority) and the loader/DMA (port 1).
//   A wait counter lets port 1 override port 0 after STARVE_LIMIT consecutive
//   denied cycles. Read data is routed back to the port that issued the read,
//   one cycle after its grant.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pN_req/we/addr/wdata  (in)    request from port N, held until pN_gnt
//   pN_gnt                (out)   request accepted this cycle (combinational)
//   pN_rvalid/rdata       (out)   read response for port N (registered valid)
//   mem_w_en/addr/d_in    (out)   drive to data memory
//   mem_d_out             (in)    registered read data from data memory
//   starve_evt            (out)   port 1 granted by starvation override
//
// Handshake: a request is a level on pN_req with its we/addr/wdata; it is
// consumed in any cycle where pN_gnt is high. Changing the request fields
// before the grant simply replaces the pending request.
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out,
  output logic              starve_evt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rsp_v_q, rsp_v_d;
  dmem_port_e       rsp_id_q, rsp_id_d;

  logic p1_override;

  // Arbitration and memory drive. Everything is held inactive during reset,
  // including the memory write enable, so memory contents survive reset.
  always_comb begin
    p1_override = 1'b0;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    mem_w_en    = 1'b0;
    mem_addr    = '0;
    mem_d_in    = '0;
    if (!rst) begin
      p1_override = p1_req && (wait_cnt_q == LIMIT_C);
      if (p1_override) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
    if (p1_gnt) begin
      mem_w_en = p1_we;
      mem_addr = p1_addr;
      mem_d_in = p1_wdata;
    end else if (p0_gnt) begin
      mem_w_en = p0_we;
      mem_addr = p0_addr;
      mem_d_in = p0_wdata;
    end
  end

  assign starve_evt = p1_override;

  // Wait counter counts consecutive cycles port 1 is refused; it restarts
  // whenever port 1 is served or withdraws, and saturates at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req || p1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT_C) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Response tracking: remember who issued the read granted this cycle.
  always_comb begin
    rsp_v_d  = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
    rsp_id_d = p1_gnt ? PORT_LOAD : PORT_PIPE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= PORT_PIPE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_v_q    <= rsp_v_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  // A read granted just before reset asserts leaves rsp_v_q set for one
  // cycle of reset; gating with rst suppresses that stale response.
  always_comb begin
    p0_rvalid = rsp_v_q && (rsp_id_q == PORT_PIPE) && !rst;
    p1_rvalid = rsp_v_q && (rsp_id_q == PORT_LOAD) && !rst;
    p0_rdata  = p0_rvalid ? mem_d_out : '0;
    p1_rdata  = p1_rvalid ? mem_d_out : '0;
  end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural data memory alongside it.
module tb_dmem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_w_en, starve_evt;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_in;
  logic [DW-1:0] mem_d_out = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_d_in(mem_d_in),
    .mem_d_out(mem_d_out), .starve_evt(starve_evt)
  );

  // Data memory: write at edge, registered read.
  logic [DW-1:0] ram [1024];
  initial for (int i = 0; i < 1024; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_w_en) ram[mem_addr] <= mem_d_in;
    mem_d_out <= ram[mem_addr];
  end

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // Model state: shadow memory, p1 denied-cycle count, pending read.
  logic [DW-1:0] shadow [1024];
  initial for (int i = 0; i < 1024; i++) shadow[i] = '0;
  int            m_wait = 0;
  logic          m_rsp_v = 0;
  logic          m_rsp_id = 0;
  logic [DW-1:0] exp_q[$];
  int            obs_wait = 0;

  always @(negedge clk) begin
    logic e_g0, e_g1, e_ovr, e_rv0, e_rv1, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd0, e_rd1;
    e_g0 = 0; e_g1 = 0; e_ovr = 0; e_rv0 = 0; e_rv1 = 0; e_wen = 0;
    e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
    if (!rst) begin
      e_ovr = p1_req && (m_wait == LIMIT);
      e_g1  = e_ovr || (p1_req && !p0_req);
      e_g0  = p0_req && !e_g1;
      if (e_g1) begin e_wen = p1_we; e_addr = p1_addr; e_din = p1_wdata; end
      if (e_g0) begin e_wen = p0_we; e_addr = p0_addr; e_din = p0_wdata; end
      if (m_rsp_v) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 1, 0);
        end else begin
          if (m_rsp_id) begin e_rv1 = 1; e_rd1 = exp_q.pop_front(); end
          else          begin e_rv0 = 1; e_rd0 = exp_q.pop_front(); end
        end
      end
    end
    chk("p0_gnt", p0_gnt, e_g0);
    chk("p1_gnt", p1_gnt, e_g1);
    chk("starve_evt", starve_evt, e_ovr);
    chk("mem_w_en", mem_w_en, e_wen);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_d_in", mem_d_in, e_din);
    chk("p0_rvalid", p0_rvalid, e_rv0);
    chk("p1_rvalid", p1_rvalid, e_rv1);
    chk("p0_rdata", p0_rdata, e_rd0);
    chk("p1_rdata", p1_rdata, e_rd1);
    if (p0_gnt && p1_gnt) chk("dual_grant", 1, 0);
    // Independent forward-progress observation on DUT outputs.
    if (!rst && p1_req && !p1_gnt) obs_wait++;
    else obs_wait = 0;
    if (p1_req) chk("p1_wait_bound", (obs_wait <= LIMIT), 1);
    // Advance model to the next cycle.
    if (rst) begin
      m_wait = 0; m_rsp_v = 0; exp_q.delete();
    end else begin
      if (!p1_req || e_g1) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      m_rsp_v = (e_g0 || e_g1) && !e_wen;
      m_rsp_id = e_g1;
      if (m_rsp_v) exp_q.push_back(shadow[e_addr]);
      if (e_wen) shadow[e_addr] = e_din;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  task automatic idle();
    drv0(0, 0, '0, '0);
    drv1(0, 0, '0, '0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [9:0] pat;
    pat = 10'b1000010000;  // bit k: p1 wins cycle k under full contention

    // 1: reset with both ports requesting
    rst = 1;
    drv0(1, 0, 10'h001, '0);
    drv1(1, 0, 10'h002, '0);
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_w_en", mem_w_en, 0);
      chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    end
    step();
    rst = 0;
    #1;
    chk("post_rst_p0_gnt", p0_gnt, 1);
    chk("post_rst_p1_gnt", p1_gnt, 0);

    // 2: single port write then read at the top address
    step(); idle();
    step(); drv1(1, 1, 10'h3FF, 32'hDEADBEEF);
    #1; chk("t2_wr_gnt", p1_gnt, 1); chk("t2_wr_wen", mem_w_en, 1);
    step(); drv1(1, 0, 10'h3FF, '0);
    #1; chk("t2_rd_gnt", p1_gnt, 1);
    step(); idle();
    #1;
    chk("t2_p1_rvalid", p1_rvalid, 1);
    chk("t2_p1_rdata", p1_rdata, 32'hDEADBEEF);
    chk("t2_p0_rvalid", p0_rvalid, 0);

    // 3: full contention, 10 cycles
    step(); idle();
    for (int k = 0; k < 10; k++) begin
      step();
      drv0(1, 0, 10'h005, '0);
      drv1(1, 0, 10'h006, '0);
      #1;
      chk("t3_p1_gnt", p1_gnt, pat[k]);
      chk("t3_starve", starve_evt, pat[k]);
      chk("t3_p0_gnt", p0_gnt, !pat[k]);
    end

    // 4: interleaved reads after seeding two words
    step(); idle(); drv0(1, 1, 10'h010, 32'h11111111);
    step(); idle(); drv1(1, 1, 10'h020, 32'h22222222);
    step(); idle(); drv0(1, 0, 10'h010, '0);
    step(); idle(); drv1(1, 0, 10'h020, '0);
    #1;
    chk("t4_p0_rvalid", p0_rvalid, 1);
    chk("t4_p0_rdata", p0_rdata, 32'h11111111);
    step(); idle();
    #1;
    chk("t4_p1_rvalid", p1_rvalid, 1);
    chk("t4_p1_rdata", p1_rdata, 32'h22222222);
    chk("t4_p0_rvalid_off", p0_rvalid, 0);

    // 5: reset in the cycle after a read grant
    step(); drv0(1, 0, 10'h010, '0);
    step(); idle(); rst = 1;
    #1; chk("t5_rvalid_rst", p0_rvalid, 0);
    step(); rst = 0; drv0(1, 0, 10'h010, '0);
    step(); idle(); drv1(1, 0, 10'h3FF, '0);
    #1; chk("t5_keep_010", p0_rdata, 32'h11111111);
    step(); idle();
    #1; chk("t5_keep_3ff", p1_rdata, 32'hDEADBEEF);

    // 6: random traffic on a small address window plus the top word
    for (int n = 0; n < 10000; n++) begin
      step();
      drv0($urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)), $urandom);
      drv1($urandom_range(0, 3) != 0, $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)), $urandom);
    end
    step(); idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_arbiter
